// File: rtl/fpu_interco_pkg.sv
// Shared constants and width helpers for the FPU sharing interconnect.
`default_nettype none

package fpu_interco_pkg;

    localparam int unsigned FPU_MAX_OUTSTANDING = 4;

    function automatic int unsigned idx_width(input int unsigned nb_cores);
        return (nb_cores > 1) ? $clog2(nb_cores) : 1;
    endfunction

    // Tag layout is {core_idx, core_id}; the index occupies the upper bits.
    function automatic int unsigned tag_width(input int unsigned nb_cores, input int unsigned id_width);
        return idx_width(nb_cores) + id_width;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_shared_arbiter_if.sv
// Core-side and FPU-side APU bundle of the shared FPU arbiter.
`default_nettype none

interface fpu_shared_arbiter_if
    import fpu_interco_pkg::*;
#(
    parameter int unsigned NB_CORES        = 4,
    parameter int unsigned ID_WIDTH        = 9,
    parameter int unsigned NB_ARGS         = 2,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned OPCODE_WIDTH    = 6,
    parameter int unsigned FLAGS_IN_WIDTH  = 15,
    parameter int unsigned FLAGS_OUT_WIDTH = 5
);
    localparam int unsigned TAG_W = tag_width(NB_CORES, ID_WIDTH);

    logic [NB_CORES-1:0]                               core_req_i;
    logic [NB_CORES-1:0]                               core_gnt_o;
    logic [NB_CORES-1:0][ID_WIDTH-1:0]                 core_ID_i;
    logic [NB_CORES-1:0][NB_ARGS-1:0][DATA_WIDTH-1:0]  core_operands_i;
    logic [NB_CORES-1:0][OPCODE_WIDTH-1:0]             core_op_i;
    logic [NB_CORES-1:0][FLAGS_IN_WIDTH-1:0]           core_flags_i;
    logic [NB_CORES-1:0]                               core_rvalid_o;
    logic [DATA_WIDTH-1:0]                             core_rdata_o;
    logic [FLAGS_OUT_WIDTH-1:0]                        core_rflags_o;
    logic [ID_WIDTH-1:0]                               core_rID_o;

    logic                                              fpu_req_o;
    logic                                              fpu_gnt_i;
    logic [TAG_W-1:0]                                  fpu_ID_o;
    logic [NB_ARGS-1:0][DATA_WIDTH-1:0]                fpu_operands_o;
    logic [OPCODE_WIDTH-1:0]                           fpu_op_o;
    logic [FLAGS_IN_WIDTH-1:0]                         fpu_flags_o;
    logic                                              fpu_rvalid_i;
    logic [DATA_WIDTH-1:0]                             fpu_rdata_i;
    logic [FLAGS_OUT_WIDTH-1:0]                        fpu_rflags_i;
    logic [TAG_W-1:0]                                  fpu_rID_i;

    logic                                              err_o;

    // Arbiter view.
    modport slave (
        input  core_req_i, core_ID_i, core_operands_i, core_op_i, core_flags_i,
        input  fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, fpu_rID_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o, core_rflags_o, core_rID_o,
        output fpu_req_o, fpu_ID_o, fpu_operands_o, fpu_op_o, fpu_flags_o,
        output err_o
    );

    // Environment view: the cores plus the FPU wrapper.
    modport master (
        output core_req_i, core_ID_i, core_operands_i, core_op_i, core_flags_i,
        output fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, fpu_rID_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o, core_rflags_o, core_rID_o,
        input  fpu_req_o, fpu_ID_o, fpu_operands_o, fpu_op_o, fpu_flags_o,
        input  err_o
    );

endinterface

`default_nettype wire

// File: rtl/fpu_rr_arb_tree.sv
// Combinational round-robin pick: first eligible index at or after rr_ptr, wrapping.
`default_nettype none

module fpu_rr_arb_tree #(
    parameter int unsigned NB_CORES = 4,
    parameter int unsigned IDX_W    = 2
) (
    input  logic [NB_CORES-1:0] eligible,
    input  logic [IDX_W-1:0]    rr_ptr,
    output logic [IDX_W-1:0]    winner,
    output logic                valid
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    // Scanning from the farthest offset down lets the nearest eligible index win.
    always_comb begin
        winner   = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NB_CORES - 1; k >= 0; k--) begin
            cand     = (int'(rr_ptr) + k) % NB_CORES;
            cand_idx = IDX_W'(cand);
            if (eligible[cand_idx]) begin
                winner = cand_idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_shared_arbiter.sv
// Shares one FPU between NB_CORES cores: round-robin request arbitration with
// tag prefixing, registered tag-steered responses and per-core outstanding throttling.
`default_nettype none

module fpu_shared_arbiter
    import fpu_interco_pkg::*;
#(
    parameter int unsigned NB_CORES        = 4,
    parameter int unsigned ID_WIDTH        = 9,
    parameter int unsigned NB_ARGS         = 2,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned OPCODE_WIDTH    = 6,
    parameter int unsigned FLAGS_IN_WIDTH  = 15,
    parameter int unsigned FLAGS_OUT_WIDTH = 5,
    parameter int unsigned MAX_OUTSTANDING = FPU_MAX_OUTSTANDING
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_shared_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = idx_width(NB_CORES);
    localparam int unsigned TAG_W = tag_width(NB_CORES, ID_WIDTH);
    localparam int unsigned CNT_W = cnt_width(MAX_OUTSTANDING);

    logic [IDX_W-1:0]           rr_ptr;
    logic [CNT_W-1:0]           outst [NB_CORES];
    logic [NB_CORES-1:0]        eligible;
    logic [IDX_W-1:0]           winner;
    logic                       win_valid;
    logic                       handshake;
    logic [NB_CORES-1:0]        inc;
    logic [NB_CORES-1:0]        dec;
    logic                       underflow;

    logic [IDX_W-1:0]           rsp_idx;
    logic [ID_WIDTH-1:0]        rsp_id;
    logic                       rsp_in_range;
    logic                       rsp_ok;

    logic [NB_CORES-1:0]        rvalid_q;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic [FLAGS_OUT_WIDTH-1:0] rflags_q;
    logic [ID_WIDTH-1:0]        rid_q;
    logic                       err_q;

    // Throttling looks only at the registered count; a same-cycle response does not unmask.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            eligible[i] = bus.core_req_i[i] && (outst[i] != CNT_W'(MAX_OUTSTANDING));
        end
    end

    fpu_rr_arb_tree #(
        .NB_CORES (NB_CORES),
        .IDX_W    (IDX_W)
    ) u_arb (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .winner   (winner),
        .valid    (win_valid)
    );

    assign handshake = win_valid && bus.fpu_gnt_i;

    always_comb begin
        bus.fpu_req_o      = win_valid;
        bus.fpu_ID_o       = '0;
        bus.fpu_operands_o = '0;
        bus.fpu_op_o       = '0;
        bus.fpu_flags_o    = '0;
        bus.core_gnt_o     = '0;
        if (win_valid) begin
            bus.fpu_ID_o          = {winner, bus.core_ID_i[winner]};
            bus.fpu_operands_o    = bus.core_operands_i[winner];
            bus.fpu_op_o          = bus.core_op_i[winner];
            bus.fpu_flags_o       = bus.core_flags_i[winner];
            bus.core_gnt_o[winner] = bus.fpu_gnt_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= (winner == IDX_W'(NB_CORES - 1)) ? '0 : winner + 1'b1;
        end
    end

    assign rsp_idx      = bus.fpu_rID_i[TAG_W-1 -: IDX_W];
    assign rsp_id       = bus.fpu_rID_i[ID_WIDTH-1:0];
    assign rsp_in_range = ({1'b0, rsp_idx} < (IDX_W + 1)'(NB_CORES));
    assign rsp_ok       = bus.fpu_rvalid_i && rsp_in_range;

    // A response to an idle core is forwarded but must not wrap its counter.
    always_comb begin
        inc       = '0;
        dec       = '0;
        underflow = 1'b0;
        if (handshake) begin
            inc[winner] = 1'b1;
        end
        if (rsp_ok) begin
            if (outst[rsp_idx] == '0) begin
                underflow = 1'b1;
            end else begin
                dec[rsp_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB_CORES; i++) begin
                outst[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_CORES; i++) begin
                if (inc[i] && !dec[i]) begin
                    outst[i] <= outst[i] + 1'b1;
                end else if (dec[i] && !inc[i]) begin
                    outst[i] <= outst[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            rflags_q <= '0;
            rid_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= '0;
            if (rsp_ok) begin
                rvalid_q[rsp_idx] <= 1'b1;
                rdata_q           <= bus.fpu_rdata_i;
                rflags_q          <= bus.fpu_rflags_i;
                rid_q             <= rsp_id;
            end
            if (underflow || (bus.fpu_rvalid_i && !rsp_in_range)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.core_rvalid_o = rvalid_q;
    assign bus.core_rdata_o  = rdata_q;
    assign bus.core_rflags_o = rflags_q;
    assign bus.core_rID_o    = rid_q;
    assign bus.err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_shared_arbiter.sv
// Directed bench for fpu_shared_arbiter with hand-computed expectations.
`default_nettype none

module tb_fpu_shared_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fpu_shared_arbiter_if bus ();

    fpu_shared_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.core_req_i      = '0;
        bus.core_ID_i       = '0;
        bus.core_operands_i = '0;
        bus.core_op_i       = '0;
        bus.core_flags_i    = '0;
        bus.fpu_gnt_i       = 1'b0;
        bus.fpu_rvalid_i    = 1'b0;
        bus.fpu_rdata_i     = '0;
        bus.fpu_rflags_i    = '0;
        bus.fpu_rID_i       = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        #1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        do_reset();

        // Reset state
        check("rst_gnt",    64'(bus.core_gnt_o),    64'h0);
        check("rst_rvalid", 64'(bus.core_rvalid_o), 64'h0);
        check("rst_rdata",  64'(bus.core_rdata_o),  64'h0);
        check("rst_err",    64'(bus.err_o),         64'h0);
        check("rst_req",    64'(bus.fpu_req_o),     64'h0);

        // Single core 2 request and its response
        bus.core_req_i[2]         = 1'b1;
        bus.core_ID_i[2]          = 9'h005;
        bus.core_op_i[2]          = 6'h01;
        bus.core_operands_i[2][0] = 32'h4000_0000;
        bus.core_operands_i[2][1] = 32'h4040_0000;
        bus.fpu_gnt_i             = 1'b1;
        #1;
        check("t1_req",  64'(bus.fpu_req_o),         64'h1);
        check("t1_tag",  64'(bus.fpu_ID_o),          64'h405);
        check("t1_gnt",  64'(bus.core_gnt_o),        64'h4);
        check("t1_op",   64'(bus.fpu_op_o),          64'h01);
        check("t1_opb",  64'(bus.fpu_operands_o[1]), 64'h4040_0000);
        tick();
        bus.core_req_i    = '0;
        bus.fpu_rvalid_i  = 1'b1;
        bus.fpu_rID_i     = 11'h405;
        bus.fpu_rdata_i   = 32'h3F80_0000;
        bus.fpu_rflags_i  = 5'h03;
        #1;
        check("t1_rv_lat", 64'(bus.core_rvalid_o), 64'h0);
        tick();
        bus.fpu_rvalid_i = 1'b0;
        bus.fpu_rdata_i  = 32'hDEAD_BEEF;
        check("t1_rvalid", 64'(bus.core_rvalid_o), 64'h4);
        check("t1_rid",    64'(bus.core_rID_o),    64'h005);
        check("t1_rdata",  64'(bus.core_rdata_o),  64'h3F80_0000);
        check("t1_rflags", 64'(bus.core_rflags_o), 64'h03);
        tick();
        check("t1_rv_off", 64'(bus.core_rvalid_o), 64'h0);
        check("t1_hold",   64'(bus.core_rdata_o),  64'h3F80_0000);
        check("t1_err",    64'(bus.err_o),         64'h0);

        // All cores requesting continuously: rotating grant
        do_reset();
        bus.core_req_i = 4'hF;
        bus.fpu_gnt_i  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rr_gnt%0d", k), 64'(bus.core_gnt_o), 64'(4'b0001 << (k % 4)));
            tick();
        end

        // FPU stalls with cores 1 and 3 requesting: pointer must hold
        do_reset();
        bus.core_req_i = 4'b1010;
        bus.fpu_gnt_i  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall_gnt%0d", k), 64'(bus.core_gnt_o), 64'h0);
            check($sformatf("stall_idx%0d", k), 64'(bus.fpu_ID_o[10:9]), 64'h1);
            tick();
        end
        bus.fpu_gnt_i = 1'b1;
        #1;
        check("stall_g1", 64'(bus.core_gnt_o), 64'b0010);
        tick();
        check("stall_g3", 64'(bus.core_gnt_o), 64'b1000);
        tick();
        check("stall_wrap", 64'(bus.core_gnt_o), 64'b0010);

        // Outstanding limit on core 0
        do_reset();
        bus.core_req_i[0] = 1'b1;
        bus.fpu_gnt_i     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("lim_gnt%0d", k), 64'(bus.core_gnt_o), 64'h1);
            tick();
        end
        bus.core_req_i[1] = 1'b1;
        #1;
        check("lim_blocked", 64'(bus.core_gnt_o), 64'b0010);
        check("lim_tag_idx", 64'(bus.fpu_ID_o[10:9]), 64'h1);
        tick();
        bus.core_req_i[1] = 1'b0;
        #1;
        check("lim_none", 64'(bus.fpu_req_o), 64'h0);
        bus.fpu_rvalid_i = 1'b1;
        bus.fpu_rID_i    = 11'h000;
        #1;
        check("lim_same_cyc", 64'(bus.core_gnt_o), 64'h0);
        tick();
        check("lim_rv0",  64'(bus.core_rvalid_o), 64'h1);
        check("lim_regr", 64'(bus.core_gnt_o),    64'h1);
        tick();
        check("lim_simul", 64'(bus.core_gnt_o), 64'h1);
        bus.fpu_rvalid_i = 1'b0;
        tick();
        check("lim_full", 64'(bus.core_gnt_o), 64'h0);
        check("lim_err",  64'(bus.err_o),      64'h0);

        // Response to an idle core, then asynchronous reset
        do_reset();
        bus.fpu_rvalid_i = 1'b1;
        bus.fpu_rID_i    = 11'h20A;
        bus.fpu_rdata_i  = 32'h1234_5678;
        tick();
        bus.fpu_rvalid_i = 1'b0;
        check("err_rvalid", 64'(bus.core_rvalid_o), 64'b0010);
        check("err_set",    64'(bus.err_o),         64'h1);
        check("err_rid",    64'(bus.core_rID_o),    64'h00A);
        tick();
        check("err_sticky", 64'(bus.err_o), 64'h1);
        check("err_rv_off", 64'(bus.core_rvalid_o), 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_err",   64'(bus.err_o),        64'h0);
        check("arst_rdata", 64'(bus.core_rdata_o), 64'h0);
        check("arst_rid",   64'(bus.core_rID_o),   64'h0);
        tick();
        rst_n = 1'b1;
        bus.core_req_i = 4'hF;
        bus.fpu_gnt_i  = 1'b1;
        #1;
        check("arst_ptr", 64'(bus.core_gnt_o), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
